// File: rtl/count_sequence_monitor.sv
// Receiver for the 0..MAX_VAL ping-pong counter stream: recovers direction, flags
// turnarounds and protocol violations, and counts completed round trips.
module count_sequence_monitor #(
    parameter int unsigned MAX_VAL = 9,
    parameter int unsigned CYC_W   = 8,
    parameter int unsigned LOCK_N  = 2
) (
    input  logic             clki,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [3:0]       q_in,
    output logic             dir,
    output logic             dir_valid,
    output logic             turn_pulse,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             locked,
    output logic [CYC_W-1:0] cycle_count
);

    localparam int unsigned STEP_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [3:0] MaxV    = 4'(MAX_VAL);
    localparam logic [3:0] MaxM1   = 4'(MAX_VAL - 1);

    typedef enum logic [1:0] {StIdle, StFirst, StUp, StDown} state_e;

    state_e              state_q, state_d;
    logic [3:0]          prev_q, prev_d;
    logic                dir_q, dir_d;
    logic                turn_q, turn_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;

    // Per-sample classification produced by the next-state logic.
    logic                legal, turn, wrap, err;
    logic [1:0]          code;
    logic                up_step, dn_step, at_max, at_zero;

    // 5-bit compares keep p+1 / p-1 from wrapping.
    assign up_step = ({1'b0, q_in} == ({1'b0, prev_q} + 5'd1));
    assign dn_step = (prev_q != 4'd0) && ({1'b0, q_in} == ({1'b0, prev_q} - 5'd1));
    assign at_max  = (prev_q == MaxV);
    assign at_zero = (prev_q == 4'd0);

    // State register.
    always_ff @(posedge clki or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            prev_q  <= 4'd0;
            dir_q   <= 1'b0;
            turn_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            step_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            dir_q   <= dir_d;
            turn_q  <= turn_d;
            err_q   <= err_d;
            code_q  <= code_d;
            step_q  <= step_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        legal   = 1'b0;
        turn    = 1'b0;
        wrap    = 1'b0;
        err     = 1'b0;
        code    = 2'b00;
        if (sample_en) begin
            if (q_in > MaxV) begin
                err     = 1'b1;
                code    = 2'b01;
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        prev_d  = q_in;
                        state_d = StFirst;
                    end
                    StFirst: begin
                        if (up_step) begin
                            legal   = 1'b1;
                            state_d = StUp;
                        end else if (dn_step) begin
                            legal   = 1'b1;
                            state_d = StDown;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    StUp: begin
                        if (!at_max && up_step) begin
                            legal = 1'b1;
                        end else if (at_max && q_in == MaxM1) begin
                            legal   = 1'b1;
                            turn    = 1'b1;
                            state_d = StDown;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    StDown: begin
                        if (!at_zero && dn_step) begin
                            legal = 1'b1;
                        end else if (at_zero && q_in == 4'd1) begin
                            legal   = 1'b1;
                            turn    = 1'b1;
                            wrap    = 1'b1;
                            state_d = StUp;
                        end else begin
                            err = 1'b1;
                        end
                    end
                    default: state_d = StIdle;
                endcase
                if (legal) begin
                    prev_d = q_in;
                end
                // In-range violation: resynchronise on the offending value.
                if (err) begin
                    prev_d  = q_in;
                    state_d = StFirst;
                    code    = (q_in == prev_q) ? 2'b11 : 2'b10;
                end
            end
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        dir_d  = dir_q;
        turn_d = turn;
        err_d  = err;
        code_d = err ? code : code_q;
        step_d = step_q;
        cyc_d  = cyc_q;
        if (state_d == StUp) begin
            dir_d = 1'b0;
        end else if (state_d == StDown) begin
            dir_d = 1'b1;
        end
        if (err) begin
            step_d = '0;
        end else if (legal && step_q != STEP_W'(LOCK_N)) begin
            step_d = step_q + 1'b1;
        end
        if (wrap && cyc_q != {CYC_W{1'b1}}) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    assign dir         = dir_q;
    assign dir_valid   = (state_q == StUp) || (state_q == StDown);
    assign turn_pulse  = turn_q;
    assign err_pulse   = err_q;
    assign err_code    = code_q;
    assign locked      = (step_q == STEP_W'(LOCK_N));
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Scoreboard bench for count_sequence_monitor: a default instance plus a CYC_W=2 instance
// sharing the same stimulus, so counter saturation is observable.
module tb_count_sequence_monitor;

    logic       clki = 1'b0;
    logic       reset = 1'b0;
    logic       sample_en = 1'b0;
    logic [3:0] q_in = 4'd0;

    logic       dir, dir_valid, turn_pulse, err_pulse, locked;
    logic [1:0] err_code;
    logic [7:0] cycle_count;

    logic       dir2, dir_valid2, turn_pulse2, err_pulse2, locked2;
    logic [1:0] err_code2;
    logic [1:0] cycle_count2;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];
    string       name_q[$];

    always #5 clki = ~clki;

    count_sequence_monitor u_dut (
        .clki        (clki),
        .reset       (reset),
        .sample_en   (sample_en),
        .q_in        (q_in),
        .dir         (dir),
        .dir_valid   (dir_valid),
        .turn_pulse  (turn_pulse),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .locked      (locked),
        .cycle_count (cycle_count)
    );

    count_sequence_monitor #(.CYC_W(2)) u_dut2 (
        .clki        (clki),
        .reset       (reset),
        .sample_en   (sample_en),
        .q_in        (q_in),
        .dir         (dir2),
        .dir_valid   (dir_valid2),
        .turn_pulse  (turn_pulse2),
        .err_pulse   (err_pulse2),
        .err_code    (err_code2),
        .locked      (locked2),
        .cycle_count (cycle_count2)
    );

    // Issue one cycle of stimulus and queue the outputs expected after that edge.
    task automatic smp(input logic en, input logic [3:0] q, input string nm,
                       input logic d, input logic dv, input logic tp, input logic ep,
                       input logic [1:0] ec, input logic lk, input logic [7:0] cc,
                       input logic [1:0] c2);
        @(negedge clki);
        sample_en = en;
        q_in      = q;
        exp_q.push_back({d, dv, tp, ep, ec, lk, cc, c2});
        name_q.push_back(nm);
    endtask

    // Assert reset between edges and confirm both instances clear before the next edge.
    task automatic do_reset(input string nm);
        logic [16:0] got;
        logic [7:0]  got2;
        @(posedge clki);
        #3;
        sample_en = 1'b0;
        reset     = 1'b0;
        #1;
        got  = {dir, dir_valid, turn_pulse, err_pulse, err_code, locked, cycle_count,
                cycle_count2};
        got2 = {dir2, dir_valid2, turn_pulse2, err_pulse2, err_code2, locked2};
        total++;
        if (got !== 17'd0 || got2 !== 8'd0) begin
            bad++;
            $display("FAIL %s: got=%h/%h want=0/0", nm, got, got2);
        end
        @(negedge clki);
        reset = 1'b1;
    endtask

    // Monitor: pop and compare one expectation per edge while any are outstanding.
    initial begin
        logic [16:0] e, got;
        string nm;
        forever begin
            @(posedge clki);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {dir, dir_valid, turn_pulse, err_pulse, err_code, locked, cycle_count,
                       cycle_count2};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got=%h want=%h", nm, got, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: full up/down sweep with turns and one round trip.
        do_reset("t0_reset");
        smp(1, 4'd0, "t1_idle",  0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd1, "t1_first", 0, 1, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        for (int v = 2; v <= 9; v++)
            smp(1, 4'(v), "t1_up", 0, 1, 0, 0, 2'b00, 1, 8'd0, 2'd0);
        for (int v = 8; v >= 0; v--)
            smp(1, 4'(v), "t1_down", 1, 1, (v == 8), 0, 2'b00, 1, 8'd0, 2'd0);
        smp(1, 4'd1, "t1_wrap", 0, 1, 1, 0, 2'b00, 1, 8'd1, 2'd1);

        // Test 2: hold error, then recovery upward.
        do_reset("t2_reset");
        smp(1, 4'd3, "t2_s3",   0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd4, "t2_s4",   0, 1, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd4, "t2_hold", 0, 0, 0, 1, 2'b11, 0, 8'd0, 2'd0);
        smp(1, 4'd5, "t2_s5",   0, 1, 0, 0, 2'b11, 0, 8'd0, 2'd0);

        // Test 3: out-of-range from S_UP, then restart; boundary MAX_VAL+1.
        do_reset("t3_reset");
        smp(1, 4'd5,  "t3_s5",  0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd6,  "t3_s6",  0, 1, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd12, "t3_oor", 0, 0, 0, 1, 2'b01, 0, 8'd0, 2'd0);
        smp(1, 4'd2,  "t3_s2",  0, 0, 0, 0, 2'b01, 0, 8'd0, 2'd0);
        smp(1, 4'd3,  "t3_s3",  0, 1, 0, 0, 2'b01, 0, 8'd0, 2'd0);
        do_reset("t3b_reset");
        smp(1, 4'd8,  "t3b_s8",  0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd9,  "t3b_s9",  0, 1, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd10, "t3b_oor", 0, 0, 0, 1, 2'b01, 0, 8'd0, 2'd0);

        // Test 4: illegal step, recovery downward, illegal step keeps dir.
        do_reset("t4_reset");
        smp(1, 4'd3, "t4_s3",  0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd4, "t4_s4",  0, 1, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd6, "t4_ill", 0, 0, 0, 1, 2'b10, 0, 8'd0, 2'd0);
        smp(1, 4'd5, "t4_dn",  1, 1, 0, 0, 2'b10, 0, 8'd0, 2'd0);
        smp(1, 4'd0, "t4_ill2", 1, 0, 0, 1, 2'b10, 0, 8'd0, 2'd0);

        // Test 5: sample_en=0 cycles are ignored, even with an out-of-range value.
        do_reset("t5_reset");
        smp(1, 4'd2, "t5_s2", 0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        for (int i = 0; i < 3; i++)
            smp(0, 4'd7, "t5_idle", 0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(0, 4'd15, "t5_idle_oor", 0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd3, "t5_s3", 0, 1, 0, 0, 2'b00, 0, 8'd0, 2'd0);

        // Test 6: four round trips; the 2-bit counter saturates at 3.
        do_reset("t6_reset");
        smp(1, 4'd0, "t6_idle",  0, 0, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        smp(1, 4'd1, "t6_first", 0, 1, 0, 0, 2'b00, 0, 8'd0, 2'd0);
        for (int r = 0; r < 4; r++) begin
            for (int v = 2; v <= 9; v++)
                smp(1, 4'(v), "t6_up", 0, 1, 0, 0, 2'b00, 1, 8'(r),
                    (r > 3) ? 2'd3 : 2'(r));
            for (int v = 8; v >= 0; v--)
                smp(1, 4'(v), "t6_down", 1, 1, (v == 8), 0, 2'b00, 1, 8'(r),
                    (r > 3) ? 2'd3 : 2'(r));
            smp(1, 4'd1, "t6_wrap", 0, 1, 1, 0, 2'b00, 1, 8'(r + 1),
                (r + 1 > 3) ? 2'd3 : 2'(r + 1));
        end
        smp(1, 4'd2, "t6_after", 0, 1, 0, 0, 2'b00, 1, 8'd4, 2'd3);
        do_reset("t6_midrun_reset");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clki);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
